// File: rtl/tictactoe_pkg.sv
// Shared encodings for the tic-tac-toe grid, players, results and the turn sequencer FSM.
package tictactoe_pkg;
  localparam int NUM_CELLS = 9;
  localparam int BOARD_W   = 2 * NUM_CELLS;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_O     = 2'd1;
  localparam logic [1:0] CELL_X     = 2'd2;

  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_P1   = 2'd1;
  localparam logic [1:0] RES_P2   = 2'd2;
  localparam logic [1:0] RES_DRAW = 2'd3;

  typedef enum logic [2:0] {WAIT, CHECK, WRITE, EVAL, OVER} seq_state_t;

  // Out-of-range addresses read back as occupied so they can never be written.
  function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b, input logic [3:0] a);
    logic [1:0] c;
    c = 2'b11;
    for (int i = 0; i < NUM_CELLS; i++)
      if (a == 4'(i)) c = b[2*i +: 2];
    return c;
  endfunction

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == P1) ? P2 : P1;
  endfunction
endpackage

// File: rtl/turn_sequencer_if.sv
// Board-side request/evaluator inputs and grid write / game status outputs of the sequencer.
interface turn_sequencer_if;
  logic                              confirm;
  logic [3:0]                        address;
  logic [tictactoe_pkg::BOARD_W-1:0] board;
  logic                              end_signal;
  logic [1:0]                        winner;
  logic                              wr_en;
  logic [3:0]                        wr_addr;
  logic [1:0]                        wr_value;
  logic [1:0]                        current_player;
  logic                              illegal_move;
  logic                              timeout;
  logic                              game_over;
  logic [1:0]                        result;
  logic [3:0]                        move_count;

  modport master (
    input  confirm, address, board, end_signal, winner,
    output wr_en, wr_addr, wr_value, current_player, illegal_move, timeout,
           game_over, result, move_count
  );

  modport slave (
    output confirm, address, board, end_signal, winner,
    input  wr_en, wr_addr, wr_value, current_player, illegal_move, timeout,
           game_over, result, move_count
  );
endinterface

// File: rtl/turn_timer.sv
// Idle-turn counter: counts while enabled and flags the last cycle of each LIMIT-cycle period.
module turn_timer #(
  parameter int TMR_W = 26,
  parameter int LIMIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [TMR_W-1:0] LAST = (LIMIT > 0) ? TMR_W'(LIMIT - 1) : '0;

  logic [TMR_W-1:0] cnt;

  assign expire = en && (LIMIT > 0) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= expire ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/turn_sequencer.sv
// Tic-tac-toe move sequencer: validates confirm requests, is the only grid writer, and
// samples the win evaluator after each write to pass the turn or end the game.
module turn_sequencer
  import tictactoe_pkg::*;
#(
  parameter int TURN_TIMEOUT = 0,
  parameter int TMR_W        = 26
) (
  input logic              clk,
  input logic              reset,
  turn_sequencer_if.master bus
);
  seq_state_t state;
  logic       confirm_q;
  logic [3:0] addr_q;
  logic [1:0] player;
  logic [1:0] result_q;
  logic [3:0] moves;
  logic       illegal_q;
  logic       timeout_q;
  logic       over_q;
  logic       req;
  logic       tmr_en;
  logic       tmr_clr;
  logic       expire;

  assign req = bus.confirm & ~confirm_q;

  // A request in the expiring cycle holds the timer off, so the move wins over the timeout.
  assign tmr_en  = (TURN_TIMEOUT != 0) && (state == WAIT) && !req;
  assign tmr_clr = (state != WAIT) || req;

  turn_timer #(.TMR_W(TMR_W), .LIMIT(TURN_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT;
      confirm_q <= 1'b1;
      addr_q    <= 4'd0;
      player    <= P1;
      result_q  <= RES_NONE;
      moves     <= 4'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      confirm_q <= bus.confirm;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        WAIT: begin
          if (req) begin
            addr_q <= bus.address;
            state  <= CHECK;
          end else if (expire) begin
            timeout_q <= 1'b1;
            player    <= other_player(player);
          end
        end
        CHECK: begin
          if (addr_q > 4'd8 || cell_at(bus.board, addr_q) != CELL_EMPTY) begin
            illegal_q <= 1'b1;
            state     <= WAIT;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: state <= EVAL;
        EVAL: begin
          moves <= moves + 4'd1;
          if (bus.end_signal) begin
            result_q <= bus.winner;
            over_q   <= 1'b1;
            state    <= OVER;
          end else if (moves == 4'(NUM_CELLS - 1)) begin
            // Full board without an evaluator verdict still ends the game as a draw.
            result_q <= RES_DRAW;
            over_q   <= 1'b1;
            state    <= OVER;
          end else begin
            player <= other_player(player);
            state  <= WAIT;
          end
        end
        OVER:    state <= OVER;
        default: state <= WAIT;
      endcase
    end
  end

  assign bus.wr_en          = (state == WRITE);
  assign bus.wr_addr        = (state == WRITE) ? addr_q : 4'd0;
  assign bus.wr_value       = (state == WRITE) ? player : 2'd0;
  assign bus.current_player = player;
  assign bus.illegal_move   = illegal_q;
  assign bus.timeout        = timeout_q;
  assign bus.game_over      = over_q;
  assign bus.result         = result_q;
  assign bus.move_count     = moves;
endmodule
